srl16_delay_line: RTL and testbench
===================================

Name: srl16_delay_line

Overview:
- 16-deep, addressable shift-register delay element with the SRL16E primitive's behaviour (CE, A0–A3, D, Q), plus a synchronous reset.
- Used to delay sample data and valid bits by a fixed or run-time-selectable 1–16 clocks, aligning sample streams with trigger-logic latency.
- One instance per bit lane; the WIDTH parameter allows lanes to be bundled.

Parameters:
- INIT, 16'h0000: power-up and reset contents of each lane's 16-bit shift register. Bit i is stage i; stage 0 is the newest.
- WIDTH, 1: number of parallel bit lanes sharing CLK, CE, reset and address.

Ports:
- CLK  input  1  clock (core_clk domain); all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset; reloads INIT into every lane.
- CE  input  1  shift enable; 1 = shift this cycle, 0 = hold contents.
- A0  input  1  tap address bit 0 (LSB).
- A1  input  1  tap address bit 1.
- A2  input  1  tap address bit 2.
- A3  input  1  tap address bit 3 (MSB).
- D  input  WIDTH  serial data in.
- Q  output  WIDTH  selected tap, combinational.

Behaviour:
- State: per lane, sr[15:0]; stage 0 is the newest entry.
- Power-up contents = INIT for every lane.
- Rising CLK, priority order:
  - RST=1: sr <= INIT for every lane, regardless of CE or D.
  - Else CE=1: sr <= {sr[14:0], D[lane]}.
  - Else: sr holds.
- Read address: addr = {A3,A2,A1,A0}, 0..15.
- Output: Q[lane] = sr[addr] for that lane.
  - Q is purely combinational from sr and addr; there is no output register.
  - An address change is reflected in Q in the same cycle.
- Latency, with CE held high: Q(t) = D(t-(addr+1)), i.e. addr+1 clock cycles of delay.
  - addr=0 gives 1 cycle; addr=15 gives 16 cycles.
  - Example: {A3..A0}=0011 gives 4 cycles; 0100 gives 5 cycles.
- Reset values:
  - After reset, Q = INIT[addr] (0 with the default INIT) until new data propagates.
  - Reset asserted mid-stream discards all stored data. On the following edges, shifting resumes from INIT contents.
- CE low: contents frozen. Q still follows address changes, so any stored stage can be read while frozen.
- Address change mid-stream: contents are unaffected; only the tap moves. Q may repeat or skip samples. This is intended for run-time delay selection.
- Bits shifted out of stage 15 are discarded.
- No X-propagation special cases: D is sampled as-is.
- No other outputs and no handshake.

Test Plan:
- Fixed delay: addr=0011, CE=1, RST=0, D = 1,0,0,0,0,0,... -> Q=1 exactly on the 4th rising edge after D=1 was sampled, 0 elsewhere.
- Full sweep: for addr=0..15, drive a single-cycle pulse on D -> Q pulses exactly addr+1 clocks later, width 1; addr=1111 gives 16.
- CE hold: shift in 1,1,0,1 with CE=1, then CE=0 for 10 cycles while D toggles -> contents unchanged. Reading addr=0,1,2,3 gives Q=1,0,1,1 (newest-first order).
- Sync reset: fill sr with all ones (16 shifts of D=1). Assert RST for one cycle with CE=1, D=1 -> Q=0 at every addr immediately after that edge. With INIT=16'hA5A5, Q at addr 0 = 1 and addr 1 = 0.
- Combinational tap: fill stages with pattern 16'h1234, CE=0, change addr each half-cycle -> Q reflects sr[addr] without waiting for a clock edge.
- Multi-lane: WIDTH=16, addr=0100, D = 16'hBEEF then 16'h0000... -> Q = 16'hBEEF exactly 5 cycles later, all lanes aligned.

Source files
------------

// File: rtl/srl16_delay_line.sv
// srl16_delay_line
// Addressable 16-stage shift-register delay line with SRL16E-style behaviour
// (CE, A0..A3, D, Q) plus a synchronous reset. Each bit lane has its own
// 16-bit shift register, and all lanes share the clock, enable, reset and tap
// address. Q is a purely combinational tap, so the delay is addr+1 clocks.

module srl16_delay_line #(
    parameter logic [15:0] INIT  = 16'h0000,  // power-up/reset contents, bit i = stage i
    parameter int          WIDTH = 1          // number of parallel bit lanes
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             A0,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Tap address: stage 0 is the newest sample.
    logic [3:0] addr;
    assign addr = {A3, A2, A1, A0};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            // Declaration initialiser gives INIT as the FPGA configuration value.
            logic [15:0] sr_reg = INIT;

            // Reset has priority over shifting; the bit leaving stage 15 is dropped.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sr_reg <= INIT;
                end else if (CE) begin
                    sr_reg <= {sr_reg[14:0], D[gi]};
                end
            end

            // Unregistered tap, so an address change shows up in the same cycle.
            assign Q[gi] = sr_reg[addr];
        end
    endgenerate

endmodule

// File: tb/tb_srl16_delay_line.sv
// Directed self-checking bench for srl16_delay_line.
// dut_w: WIDTH=16, INIT=0. dut_i: WIDTH=1, INIT=16'hA5A5, fed from lane 0.

module tb_srl16_delay_line;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] q_w;
    logic [0:0]  q_i;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    srl16_delay_line #(.INIT(16'h0000), .WIDTH(16)) dut_w (
        .CLK(clk), .RST(rst), .CE(ce),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
        .D(d), .Q(q_w)
    );

    srl16_delay_line #(.INIT(16'hA5A5), .WIDTH(1)) dut_i (
        .CLK(clk), .RST(rst), .CE(ce),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
        .D(d[0:0]), .Q(q_i)
    );

    // Advance one rising edge and settle; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("vec %0d %s ok q=%h", vectors, tag, obs);
        end else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] pat;

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        a   = 4'd0;
        d   = 16'h0000;

        // Reset state: wide DUT all zero, narrow DUT shows INIT bits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("reset_w_a%0d", i), q_w, 16'h0000);
            check($sformatf("reset_i_a%0d", i), {15'd0, q_i}, {15'd0, (i % 2 == 0) ? 1'b1 : 1'b0});
        end

        // Fixed delay at addr=3: pulse appears exactly 4 edges after being sampled.
        ce = 1'b1;
        a  = 4'd3;
        d  = 16'h0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            d = 16'h0000;
            check($sformatf("fixed_a3_t%0d", i), q_w, (i == 4) ? 16'h0001 : 16'h0000);
        end

        // Sweep every tap: a one-cycle pulse emerges after addr+1 edges, width 1.
        for (int ad = 0; ad < 16; ad++) begin
            do_reset();
            a = 4'(ad);
            d = 16'hFFFF;
            for (int i = 1; i <= 18; i++) begin
                tick();
                d = 16'h0000;
                check($sformatf("sweep_a%0d_t%0d", ad, i), q_w,
                      (i == ad + 1) ? 16'hFFFF : 16'h0000);
            end
        end

        // CE hold: shift 1,1,0,1 then freeze while D toggles.
        do_reset();
        ce  = 1'b1;
        pat = 16'b1101;
        for (int i = 0; i < 4; i++) begin
            d = pat[3 - i] ? 16'hFFFF : 16'h0000;
            tick();
        end
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            tick();
        end
        pat = 16'b1101;  // stage0=1, stage1=0, stage2=1, stage3=1
        for (int i = 0; i < 4; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("hold_a%0d", i), q_w, pat[i] ? 16'hFFFF : 16'h0000);
        end
        a = 4'd4;
        #1;
        check("hold_a4", q_w, 16'h0000);

        // Sync reset over a full register, with CE=1 and D=1 on the reset edge.
        ce = 1'b1;
        d  = 16'hFFFF;
        for (int i = 0; i < 16; i++) tick();
        a = 4'd15;
        #1;
        check("full_a15", q_w, 16'hFFFF);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("srst_w_a%0d", i), q_w, 16'h0000);
        end
        a = 4'd0;
        #1;
        check("srst_i_a0", {15'd0, q_i}, 16'h0001);
        a = 4'd1;
        #1;
        check("srst_i_a1", {15'd0, q_i}, 16'h0000);
        rst = 1'b0;

        // Combinational tap: load 16'h1234, freeze, move the tap every half cycle.
        pat = 16'h1234;
        ce  = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            d = pat[i] ? 16'hFFFF : 16'h0000;
            tick();
        end
        ce = 1'b0;
        d  = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("comb_a%0d", i), q_w, pat[i] ? 16'hFFFF : 16'h0000);
            #4;
        end

        // Multi-lane alignment at addr=4: BEEF emerges after exactly 5 edges.
        do_reset();
        ce = 1'b1;
        a  = 4'd4;
        d  = 16'hBEEF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            d = 16'h0000;
            check($sformatf("lanes_a4_t%0d", i), q_w, (i == 5) ? 16'hBEEF : 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
